// File: rtl/audio_i2s_pkg.sv
// Shared I2S frame constants and helpers for the audio receive and transmit paths.
package audio_i2s_pkg;

  localparam int AUDIO_W = 16;
  localparam int SLOTS   = 32;
  localparam int SLOT_W  = $clog2(SLOTS);

  typedef logic [AUDIO_W-1:0] sample_t;
  typedef logic [SLOT_W-1:0]  slot_t;

  // MSB of each word sits one slot after the lrck edge; right LSB spills into slot 0.
  localparam slot_t LEFT_FIRST     = 5'd1;
  localparam slot_t LEFT_LAST      = 5'd16;
  localparam slot_t RIGHT_FIRST    = 5'd17;
  localparam slot_t RIGHT_LSB_SLOT = 5'd0;

  // Magnitude of a two's-complement sample; -32768 saturates to the largest positive value.
  function automatic sample_t sat_abs(input sample_t x);
    if (x == 16'h8000) return 16'h7FFF;
    if (x[AUDIO_W-1])  return ~x + 1'b1;
    return x;
  endfunction

endpackage

// File: rtl/audio_i2s_timing.sv
// Free-running frame counter: derives mclk/lrck/sck and the per-slot capture strobe.
module audio_i2s_timing
  import audio_i2s_pkg::*;
#(
  parameter int BIT_LOG2     = 4,
  parameter int SAMPLE_PHASE = 10
) (
  input  logic                clk,
  input  logic                rst,
  output slot_t               slot,
  output logic [BIT_LOG2-1:0] phase,
  output logic                capture,
  output logic                mclk,
  output logic                lrck,
  output logic                sck
);

  localparam int CW = SLOT_W + BIT_LOG2;

  logic [CW-1:0] cnt;

  // Counter wraps once per frame; reset restarts timing at slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 1'b1;
  end

  assign slot    = cnt[CW-1:BIT_LOG2];
  assign phase   = cnt[BIT_LOG2-1:0];
  assign capture = (phase == BIT_LOG2'(SAMPLE_PHASE));
  assign mclk    = cnt[1];
  assign lrck    = cnt[CW-1];
  assign sck     = cnt[BIT_LOG2-1];

endmodule

// File: rtl/i2s_audio_receiver.sv
// I2S master-mode receiver: deserializes ADC frames into a valid/ready sample pair.
// Optional feature: define AUDIO_RX_PEAK_EN for per-channel peak magnitude tracking.
module i2s_audio_receiver
  import audio_i2s_pkg::*;
#(
  parameter int BIT_LOG2     = 4,
  parameter int SAMPLE_PHASE = 10
) (
  input  logic    clk,
  input  logic    rst,
`ifdef AUDIO_RX_PEAK_EN
  input  logic    peak_clear,
  output sample_t peak_left,
  output sample_t peak_right,
`endif
  input  logic    audio_sdout,
  output logic    audio_mclk,
  output logic    audio_lrck,
  output logic    audio_sck,
  output sample_t sample_left,
  output sample_t sample_right,
  output logic    sample_valid,
  input  logic    sample_ready,
  output logic    overrun,
  input  logic    clear_overrun
);

  slot_t               slot;
  logic [BIT_LOG2-1:0] phase;
  logic                capture;

  audio_i2s_timing #(.BIT_LOG2(BIT_LOG2), .SAMPLE_PHASE(SAMPLE_PHASE)) u_timing (
    .clk     (clk),
    .rst     (rst),
    .slot    (slot),
    .phase   (phase),
    .capture (capture),
    .mclk    (audio_mclk),
    .lrck    (audio_lrck),
    .sck     (audio_sck)
  );

  // The capture strobe already encodes the phase, so the raw phase is not needed here.
  logic timing_unused;
  assign timing_unused = ^phase;

  logic               sync1, sync2;
  sample_t            left_sh;
  logic [AUDIO_W-2:0] right_sh;
  logic               right_lsb;
  logic               load;
  logic               primed;

  // Two-flop synchronizer for the asynchronous ADC data line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= audio_sdout;
      sync2 <= sync1;
    end
  end

  // Slot-mapped shift-in; slot 0 carries the right LSB and completes the pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_sh   <= '0;
      right_sh  <= '0;
      right_lsb <= 1'b0;
      load      <= 1'b0;
      primed    <= 1'b0;
    end else begin
      load <= 1'b0;
      if (capture) begin
        if (slot >= LEFT_FIRST && slot <= LEFT_LAST)
          left_sh <= {left_sh[AUDIO_W-2:0], sync2};
        else if (slot >= RIGHT_FIRST)
          right_sh <= {right_sh[AUDIO_W-3:0], sync2};
        else if (slot == RIGHT_LSB_SLOT) begin
          right_lsb <= sync2;
          load      <= primed;
        end
        // A full left word seen since reset means the next slot-0 completes a whole frame.
        if (slot == LEFT_LAST) primed <= 1'b1;
      end
    end
  end

  sample_t new_left, new_right;
  logic    overrun_evt;

  assign new_left    = left_sh;
  assign new_right   = {right_sh, right_lsb};
  assign overrun_evt = load && sample_valid && !sample_ready;

  // Holding register: a load always wins; otherwise a handshake empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
    end else if (load) begin
      sample_left  <= new_left;
      sample_right <= new_right;
      sample_valid <= 1'b1;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

  // Sticky overrun; a new event beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                overrun <= 1'b0;
    else if (overrun_evt)   overrun <= 1'b1;
    else if (clear_overrun) overrun <= 1'b0;
  end

`ifdef AUDIO_RX_PEAK_EN
  sample_t abs_left, abs_right;
  assign abs_left  = sat_abs(new_left);
  assign abs_right = sat_abs(new_right);

  // Peak hold per channel; a clear coinciding with a load restarts from the new sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_left  <= '0;
      peak_right <= '0;
    end else if (load) begin
      peak_left  <= (peak_clear || abs_left  > peak_left)  ? abs_left  : peak_left;
      peak_right <= (peak_clear || abs_right > peak_right) ? abs_right : peak_right;
    end else if (peak_clear) begin
      peak_left  <= '0;
      peak_right <= '0;
    end
  end
`endif

endmodule
